add_seq_ctrl: RTL
=================

# add_seq_ctrl

Multi-cycle sequencer that drives one external WIDTH-bit adder, such as `Ripple_Carry_Adder`, to add operands of WIDTH*CHUNKS bits. The adder is used once per chunk, from least-significant chunk to most-significant chunk, and the carry is chained through a register. Wide additions therefore reuse a single narrow adder instance in exchange for latency. The block has a valid/ready request interface upstream and a valid/ready response interface downstream, and it sits between the requester and the shared adder.

## Interface
- `WIDTH`, default 8: width of the external adder, and of one chunk.
- `CHUNKS`, default 4: number of chunks per operation; must be ≥ 2. The full operand width is `W = WIDTH*CHUNKS`.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `req_valid` input, 1 bit: request present.
- `req_ready` output, 1 bit: block accepts a request.
- `req_a` input, W bits: operand A.
- `req_b` input, W bits: operand B.
- `req_cin` input, 1 bit: carry-in to chunk 0.
- `rsp_valid` output, 1 bit: result present.
- `rsp_ready` input, 1 bit: consumer accepts the result.
- `rsp_sum` output, W bits: the sum.
- `rsp_cout` output, 1 bit: carry-out of the most-significant chunk.
- `rsp_ovf` output, 1 bit: signed overflow flag (see Configuration).
- `add_a` output, WIDTH bits: adder operand A.
- `add_b` output, WIDTH bits: adder operand B.
- `add_cin` output, 1 bit: adder carry-in.
- `add_s` input, WIDTH bits: adder sum, combinational from `add_a`/`add_b`/`add_cin`.
- `add_cout` input, 1 bit: adder carry-out.

## Operation
- **States:** IDLE, RUN, DONE. Registers hold the operands, a chunk index `idx` (⌈log2 CHUNKS⌉ bits), the carry, and the sum.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid & req_ready`: latch `req_a`, `req_b`; set carry=`req_cin`, `idx`=0; go to RUN.
- **RUN:**
  - Drive `add_a`=a[idx*WIDTH +: WIDTH], `add_b`=b[idx*WIDTH +: WIDTH], `add_cin`=carry.
  - Each cycle: sum[idx*WIDTH +: WIDTH] ← `add_s`; carry ← `add_cout`; `idx` ← `idx`+1.
  - When `idx`==CHUNKS-1: go to DONE instead of incrementing.
- **DONE:**
  - `rsp_valid`=1. `rsp_cout` = final carry.
  - `rsp_sum`, `rsp_cout` and `rsp_ovf` are held stable until `rsp_valid & rsp_ready`, then the state goes to IDLE.
- **Outside RUN:** `add_a`, `add_b` and `add_cin` are driven to 0.
- **Adder contract:** the adder must be purely combinational and settle within one clock.
- **Arithmetic:** modulo 2^W. `{rsp_cout, rsp_sum}` = `req_a + req_b + req_cin`, computed W+1 bits wide.
- **Input sampling:**
  - `req_valid` is ignored outside IDLE.
  - Operands are sampled only at acceptance. Later changes to `req_*` have no effect.
- **Reset:**
  - Synchronous, so it is sampled at the clock edge; this applies in any state, including mid-RUN and DONE.
  - On reset: state → IDLE, `idx`=0, carry=0, sum=0. Any in-flight operation is discarded and no response is produced.
- **Reset values of outputs:**
  - `req_ready`=1 (state IDLE).
  - `rsp_valid`=0, `rsp_sum`=0, `rsp_cout`=0, `rsp_ovf`=0.
  - `add_a`=0, `add_b`=0, `add_cin`=0.
  - `req_ready` is also forced to 0 in any cycle where `rst`=1.

## Timing
- Request accepted at edge T. RUN occupies cycles T+1 … T+CHUNKS, one chunk per cycle. `rsp_valid` rises in cycle T+CHUNKS+1.
- Accept-to-`rsp_valid` latency is CHUNKS+1 cycles; with CHUNKS=4 that is 5.
- Response handshake at edge R: IDLE in cycle R+1, `req_ready`=1, and a new request can be accepted at edge R+1.
- Best-case throughput is one operation per CHUNKS+2 cycles.
- No overlap of operations: `req_ready` and `rsp_valid` are never both 1.
- Backpressure: while `rsp_ready`=0, DONE persists indefinitely and the outputs are unchanged.
- Combinational path: `add_a`/`add_b`/`add_cin` → adder → `add_s`/`add_cout` → the block's registers within one cycle. No other combinational input-to-output paths exist; in particular, `req_ready` does not depend on `req_valid`.

## Configuration
- **Macro:** `ADD_SEQ_OVERFLOW_EN`.
- **With the macro defined:**
  - During the last RUN cycle, also register `ovf = add_a[WIDTH-1] ~^ add_b[WIDTH-1]` AND (`add_s[WIDTH-1]` ^ `add_a[WIDTH-1]`). This is two's-complement overflow of the full W-bit signed add.
  - `rsp_ovf` presents this flag in DONE.
- **Without the macro:**
  - `rsp_ovf` is tied to 0.
  - No overflow register is synthesized.
  - All other behaviour is identical.

## Test plan
All cases use WIDTH=8, CHUNKS=4.
- **Carry across chunks:** a=0x000000FF, b=0x00000001, cin=0 → `rsp_sum`=0x00000100, `rsp_cout`=0, `rsp_valid` 5 cycles after acceptance.
- **Full ripple with carry-out:** a=0xFFFFFFFF, b=0, cin=1 → sum=0x00000000, cout=1; `add_cin`=1 in each of the 4 RUN cycles.
- **Overflow:** a=0x7FFFFFFF, b=0x00000001 → sum=0x80000000, cout=0; `rsp_ovf`=1 with `ADD_SEQ_OVERFLOW_EN`, 0 without. Also a=0x12345678, b=0x11111111 → sum=0x23456789, ovf=0.
- **Backpressure:** hold `rsp_ready`=0 for 3 cycles after `rsp_valid` → `rsp_valid`, sum and cout stable and `req_ready`=0 throughout; a `req_valid` pulse in that window is ignored. On release, IDLE follows in the next cycle.
- **Back-to-back:** `req_valid` held high with two requests and `rsp_ready`=1 → second acceptance exactly 6 cycles after the first; both results correct.
- **Reset mid-operation:** assert `rst` for 1 cycle at the 2nd RUN cycle → next cycle IDLE, `req_ready`=1, `rsp_valid` never asserted for the aborted request; a subsequent request 0x1+0x2 returns 0x00000003.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// Chunk-serial wide adder sequencer: drives one external WIDTH-bit adder CHUNKS times, LSB chunk first.
// Optional signed-overflow flag is built only when ADD_SEQ_OVERFLOW_EN is defined.
module add_seq_ctrl #(
   parameter int WIDTH  = 8,
   parameter int CHUNKS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [WIDTH*CHUNKS-1:0]   req_a,
   input  logic [WIDTH*CHUNKS-1:0]   req_b,
   input  logic                      req_cin,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [WIDTH*CHUNKS-1:0]   rsp_sum,
   output logic                      rsp_cout,
   output logic                      rsp_ovf,
   output logic [WIDTH-1:0]          add_a,
   output logic [WIDTH-1:0]          add_b,
   output logic                      add_cin,
   input  logic [WIDTH-1:0]          add_s,
   input  logic                      add_cout,
   output logic [1:0]                dbg_state_o
);

   localparam int IDXW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic [CHUNKS-1:0][WIDTH-1:0]  a_q, a_d;
   logic [CHUNKS-1:0][WIDTH-1:0]  b_q, b_d;
   logic [CHUNKS-1:0][WIDTH-1:0]  sum_q, sum_d;
   logic                          carry_q, carry_d;
   logic [IDXW-1:0]               idx_q, idx_d;
   logic                          last_chunk;

   assign last_chunk  = (idx_q == IDXW'(CHUNKS - 1));
   assign dbg_state_o = state_q;

   // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
   // ready never looks at valid, and req_ready/rsp_valid are mutually exclusive.
   assign req_ready = (state_q == ST_IDLE) && !rst;
   assign rsp_valid = (state_q == ST_DONE);
   assign rsp_sum   = sum_q;
   assign rsp_cout  = rsp_valid & carry_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
               carry_d = req_cin;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            add_a        = a_q[idx_q];
            add_b        = b_q[idx_q];
            add_cin      = carry_q;
            sum_d[idx_q] = add_s;
            carry_d      = add_cout;
            if (last_chunk) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         ST_DONE: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef ADD_SEQ_OVERFLOW_EN
   logic ovf_q, ovf_d;

   // The top chunk's sign bits decide two's-complement overflow of the whole W-bit add.
   always_comb begin
      ovf_d = ovf_q;
      if (state_q == ST_RUN && last_chunk) begin
         ovf_d = (add_a[WIDTH-1] ~^ add_b[WIDTH-1]) & (add_s[WIDTH-1] ^ add_a[WIDTH-1]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign rsp_ovf = rsp_valid & ovf_q;
`else
   assign rsp_ovf = 1'b0;
`endif

endmodule
